mem_arbiter_2req: RTL and testbench
===================================

Name: mem_arbiter_2req

Overview:
- Round-robin arbiter and access sequencer that shares one memSequential instance between two requesters (port 0, port 1).
- Instantiates memSequential #(M,K) internally and drives its A/WD/WE from registered, granted operands.
- Each requester sees a req/ack handshake with a fixed 3-cycle access.
- Sits between two bus-master blocks (e.g. CPU fetch/data units) and the shared modular memory.

Parameters:
M, 8, memory cell width in bits (passed to memSequential)
K, 11, address width in bits; capacity 2^K cells (passed to memSequential)

Ports:
clock  input  1  system clock, rising-edge active
reset_n  input  1  asynchronous active-low reset
req0  input  1  requester 0 access request, held until ack0
we0  input  1  requester 0 operation: 1 = write, 0 = read
addr0  input  K  requester 0 cell address
wdata0  input  M  requester 0 write data
req1  input  1  requester 1 access request, held until ack1
we1  input  1  requester 1 operation: 1 = write, 0 = read
addr1  input  K  requester 1 cell address
wdata1  input  M  requester 1 write data
ack0  output  1  one-cycle completion pulse for requester 0
ack1  output  1  one-cycle completion pulse for requester 1
rdata  output  M  read result, valid while ack0 or ack1 is high after a read
busy  output  1  1 while an access is in progress (states ACCESS, DONE)

Behaviour:
- Reset (reset_n low, asynchronous):
  - state = IDLE; ack0 = ack1 = 0; busy = 0; rdata = 0.
  - Priority pointer = 0; internal memory WE = 0 immediately.
  - Memory contents are not cleared.
- FSM states: IDLE, ACCESS, DONE. All transitions occur on the rising edge of clock.
- IDLE:
  - If neither req is high: stay in IDLE.
  - If exactly one req is high: grant that requester.
  - If both are high: grant the requester named by the priority pointer.
  - On grant, register granted id, we, addr and wdata at the edge, then go to ACCESS.
  - req/we/addr/wdata must be stable in the IDLE cycle in which they are sampled; later changes are ignored.
- ACCESS (exactly 1 cycle):
  - Memory A = registered addr; WD = registered wdata; WE = registered we; WE is 1 only in this state.
  - A write commits at the rising edge that ends ACCESS.
  - A read loads memory RA into the rdata register at that same edge.
  - On a write, rdata keeps its previous value.
  - Go to DONE.
- DONE (exactly 1 cycle):
  - ack of the granted requester = 1; the other ack = 0.
  - Priority pointer is set to the non-served requester at the edge leaving DONE.
  - Go to IDLE.
- Latency and throughput:
  - Request sampled at edge E; WE active in cycle E..E+1; ack high in cycle E+1..E+2.
  - At most one access per 3 cycles.
- Handshake:
  - A req still high in the IDLE cycle after its ack is a new request (back-to-back accesses are allowed).
  - A requester that wants a single access drops req in the cycle following ack.
  - A req dropped before ack while the block is busy is not cancelled; the access completes and ack still pulses.
- Address decode is done by memSequential: A[K-1] selects the bank.
  - Addresses 0 .. 2^(K-1)-1 map to module1; the rest map to module2.
- Simultaneous events:
  - Requests arriving in ACCESS or DONE wait; they are evaluated only in IDLE.
  - Fairness: under continuous contention, grants alternate 0,1,0,1…
- Outputs ack0, ack1, busy and rdata are registered (no combinational path from req).
- Mid-operation reset:
  - Asserted during ACCESS: the write is aborted, memory is unchanged at that address, and no ack is issued.
  - Asserted during DONE: the ack is suppressed.

Test Plan:
- Reset behaviour: apply reset_n=0 with req0=req1=1 -> ack0=ack1=busy=0, rdata=0; release reset -> requester 0 is granted first (pointer=0).
- Basic write then read: req0 write addr0=0x005, wdata0=0xA5, then req0 read addr0=0x005 -> ack0 in the 3rd cycle of each access; read returns rdata=0xA5; ack1 stays 0.
- Bank select: req1 writes 0x3C at 0x405 and req0 writes 0xC3 at 0x005; read both -> 0x405 returns 0x3C and 0x005 returns 0xC3 (no aliasing across A[K-1]).
- Contention: req0 and req1 both held high for 4 accesses -> grant order 0,1,0,1; each ack is one cycle, spaced 3 cycles apart.
- Reset mid-write: req1 writes 0xFF at 0x7FF, with reset_n pulsed low during ACCESS -> no ack1; a subsequent read of 0x7FF returns its prior value.
- Sustained single requester: req0 held high with incrementing addresses for 5 reads -> ack0 every 3 cycles, busy high except in IDLE cycles.

Source files
------------

// File: rtl/mem_arbiter_2req.sv
// -----------------------------------------------------------------------------
// memSequential
//   Two-bank modular memory of 2^K cells of M bits each. A[K-1] selects the
//   bank (module1 for the low half of the address space, module2 for the high
//   half). Writes commit on the rising clock edge while WE is high. The read
//   port RA is combinational from A. Contents have no reset.
//   Ports: clock (in), A[K-1:0] (in), WD[M-1:0] (in), WE (in), RA[M-1:0] (out)
// -----------------------------------------------------------------------------
module memSequential #(
  parameter int M = 8,
  parameter int K = 11
) (
  input  logic         clock,
  input  logic [K-1:0] A,
  input  logic [M-1:0] WD,
  input  logic         WE,
  output logic [M-1:0] RA
);

  logic [M-1:0] module1 [2**(K-1)];
  logic [M-1:0] module2 [2**(K-1)];

  always_ff @(posedge clock) begin
    if (WE) begin
      if (A[K-1]) module2[A[K-2:0]] <= WD;
      else        module1[A[K-2:0]] <= WD;
    end
  end

  assign RA = A[K-1] ? module2[A[K-2:0]] : module1[A[K-2:0]];

endmodule

// -----------------------------------------------------------------------------
// mem_arbiter_2req
//   Round-robin arbiter that shares one memSequential between two requesters.
//   Each access is IDLE (sample) -> ACCESS (memory cycle) -> DONE (ack pulse),
//   so at most one access completes every 3 cycles.
//   Ports:
//     clock, reset_n            clock / asynchronous active-low reset
//     reqN, weN, addrN, wdataN  requester N request, op, address, write data
//     ack0, ack1                one-cycle completion pulses (registered)
//     rdata                     read result, valid with the ack of a read
//     busy                      high while in ACCESS or DONE (registered)
// -----------------------------------------------------------------------------
module mem_arbiter_2req #(
  parameter int M = 8,
  parameter int K = 11
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         req0,
  input  logic         we0,
  input  logic [K-1:0] addr0,
  input  logic [M-1:0] wdata0,
  input  logic         req1,
  input  logic         we1,
  input  logic [K-1:0] addr1,
  input  logic [M-1:0] wdata1,
  output logic         ack0,
  output logic         ack1,
  output logic [M-1:0] rdata,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t       state_q, state_d;
  logic         gnt_q, gnt_d;      // id of the requester being served
  logic         prio_q, prio_d;    // requester that wins a tie
  logic         we_q, we_d;
  logic [K-1:0] addr_q, addr_d;
  logic [M-1:0] wdata_q, wdata_d;
  logic [M-1:0] rdata_q, rdata_d;
  logic         ack0_q, ack0_d;
  logic         ack1_q, ack1_d;
  logic         busy_q, busy_d;

  logic         mem_we;
  logic [M-1:0] mem_ra;

  // WE is decoded from the async-reset state register, so a reset during
  // ACCESS drops it immediately and the pending write never commits.
  assign mem_we = (state_q == ACCESS) && we_q;

  memSequential #(.M(M), .K(K)) u_mem (
    .clock (clock),
    .A     (addr_q),
    .WD    (wdata_q),
    .WE    (mem_we),
    .RA    (mem_ra)
  );

  always_comb begin
    logic sel;
    state_d = state_q;
    gnt_d   = gnt_q;
    prio_d  = prio_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    sel     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          // Tie goes to the pointer; otherwise whichever one is asking.
          sel     = (req0 && req1) ? prio_q : req1;
          gnt_d   = sel;
          we_d    = sel ? we1    : we0;
          addr_d  = sel ? addr1  : addr0;
          wdata_d = sel ? wdata1 : wdata0;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (!we_q) rdata_d = mem_ra;
        ack0_d  = ~gnt_q;
        ack1_d  = gnt_q;
        state_d = DONE;
      end
      DONE: begin
        prio_d  = ~gnt_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_d = (state_d != IDLE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      prio_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      prio_q  <= prio_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      busy_q  <= busy_d;
    end
  end

  assign ack0  = ack0_q;
  assign ack1  = ack1_q;
  assign rdata = rdata_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_mem_arbiter_2req.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter_2req
//   Directed bench for mem_arbiter_2req: reset, contention ordering, basic
//   write/read, bank select, reset during ACCESS and a sustained read stream.
//   Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_mem_arbiter_2req;

  logic        clk;
  logic        reset_n;
  logic        req0, we0, req1, we1;
  logic [10:0] addr0, addr1;
  logic [7:0]  wdata0, wdata1;
  logic        ack0, ack1, busy;
  logic [7:0]  rdata;

  int n_checks = 0;
  int n_errors = 0;

  mem_arbiter_2req #(.M(8), .K(11)) dut (
    .clock   (clk),
    .reset_n (reset_n),
    .req0    (req0),
    .we0     (we0),
    .addr0   (addr0),
    .wdata0  (wdata0),
    .req1    (req1),
    .we1     (we1),
    .addr1   (addr1),
    .wdata1  (wdata1),
    .ack0    (ack0),
    .ack1    (ack1),
    .rdata   (rdata),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One complete access from an IDLE falling edge; returns at the next IDLE
  // falling edge with both requests dropped.
  task automatic access(input bit port, input bit we, input logic [10:0] addr,
                        input logic [7:0] wd, input logic [7:0] exp_rd, input bit chk_rd);
    int cyc;
    bit seen;
    if (port == 1'b0) begin
      req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wd;
    end else begin
      req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wd;
    end
    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc < 10) begin
      @(negedge clk);
      cyc++;
      if (ack0 || ack1) seen = 1'b1;
    end
    check("ack_latency", cyc, 2);
    check("ack_port", {ack1, ack0}, port ? 2'b10 : 2'b01);
    if (chk_rd) check("rdata", rdata, exp_rd);
    req0 = 1'b0;
    req1 = 1'b0;
    @(negedge clk);
    check("idle_after", {busy, ack1, ack0}, 3'b000);
  endtask

  initial begin
    int idx;
    // Reset with both requests already asserted.
    reset_n = 1'b0;
    req0 = 1'b1; we0 = 1'b1; addr0 = 11'h010; wdata0 = 8'h55;
    req1 = 1'b1; we1 = 1'b1; addr1 = 11'h410; wdata1 = 8'h66;
    repeat (3) @(negedge clk);
    check("reset_outs", {busy, ack1, ack0}, 3'b000);
    check("reset_rdata", rdata, 8'h00);

    // Contention: grants must go 0,1,0,1 with acks 3 cycles apart.
    reset_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      check("contend_ack", {ack1, ack0},
            (k == 2 || k == 8) ? 2'b01 : (k == 5 || k == 11) ? 2'b10 : 2'b00);
      check("contend_busy", busy, (k % 3) != 0);
      if (k == 11) begin
        req0 = 1'b0;
        req1 = 1'b0;
      end
    end
    check("contend_rdata", rdata, 8'h00);

    // Basic write then read on port 0.
    access(1'b0, 1'b1, 11'h005, 8'hA5, 8'h00, 1'b0);
    access(1'b0, 1'b0, 11'h005, 8'h00, 8'hA5, 1'b1);

    // Bank select: same low address bits, different banks.
    access(1'b1, 1'b1, 11'h405, 8'h3C, 8'h00, 1'b0);
    access(1'b0, 1'b1, 11'h005, 8'hC3, 8'h00, 1'b0);
    access(1'b1, 1'b0, 11'h405, 8'h00, 8'h3C, 1'b1);
    access(1'b0, 1'b0, 11'h005, 8'h00, 8'hC3, 1'b1);
    // Data written during the contention phase.
    access(1'b0, 1'b0, 11'h010, 8'h00, 8'h55, 1'b1);
    access(1'b1, 1'b0, 11'h410, 8'h00, 8'h66, 1'b1);

    // Reset during ACCESS of a write must abort it.
    access(1'b1, 1'b1, 11'h7FF, 8'h11, 8'h00, 1'b0);
    req1 = 1'b1; we1 = 1'b1; addr1 = 11'h7FF; wdata1 = 8'hFF;
    @(negedge clk);
    check("midrst_busy_before", busy, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_outs", {busy, ack1, ack0}, 3'b000);
    check("midrst_rdata", rdata, 8'h00);
    req1 = 1'b0;
    @(negedge clk);
    check("midrst_no_ack", ack1, 1'b0);
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("midrst_quiet", {busy, ack1}, 2'b00);
    end
    access(1'b1, 1'b0, 11'h7FF, 8'h00, 8'h11, 1'b1);

    // Sustained reads by a single requester.
    for (int i = 0; i < 5; i++)
      access(1'b0, 1'b1, 11'h100 + 11'(i), 8'h20 + 8'(i), 8'h00, 1'b0);
    idx = 0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 11'h100;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      check("stream_ack", {ack1, ack0}, (k % 3 == 2) ? 2'b01 : 2'b00);
      check("stream_busy", busy, (k % 3) != 0);
      if (ack0) begin
        check("stream_rdata", rdata, 8'h20 + 8'(idx));
        idx++;
        if (idx == 5) req0 = 1'b0;
        else addr0 = 11'h100 + 11'(idx);
      end
    end
    check("stream_count", idx, 5);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench did not complete");
  end

endmodule
